// File: rtl/priority_mux_pkg.sv
// priority_mux_pkg: shared widths and input index codes for the 6:1 priority mux
package priority_mux_pkg;
  localparam int DATA_W = 8;
  localparam int SEL_W = 5;
  localparam int NUM_IN = 6;
  localparam logic [2:0] IDX_D0 = 3'd0;
  localparam logic [2:0] IDX_D1 = 3'd1;
  localparam logic [2:0] IDX_D2 = 3'd2;
  localparam logic [2:0] IDX_D3 = 3'd3;
  localparam logic [2:0] IDX_D4 = 3'd4;
  localparam logic [2:0] IDX_D5 = 3'd5;
endpackage

// File: rtl/priority_mux_6_to_1_pri_enc.sv
// pri_enc_5: highest-set-bit encoder, bit n maps to index n+1, all-zero maps to 0
module pri_enc_5
  import priority_mux_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output logic [2:0]       idx
);
  always_comb
    idx = sel[4] ? IDX_D5 :
          sel[3] ? IDX_D4 :
          sel[2] ? IDX_D3 :
          sel[1] ? IDX_D2 :
          sel[0] ? IDX_D1 : IDX_D0;
endmodule

// File: rtl/priority_mux_6_to_1.sv
// priority_mux_6_to_1: six-input priority mux with registered data and index
module priority_mux_6_to_1
  import priority_mux_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] d_out,
  output logic [2:0]       sel_idx
);
  if (SEL_W != 5) begin : g_bad_sel_w
    $error("priority_mux_6_to_1: SEL_W must be 5");
  end
  logic [2:0]       idx;
  logic [WIDTH-1:0] d_out_d, d_out_q;
  logic [2:0]       sel_idx_d, sel_idx_q;
  pri_enc_5 u_enc (
    .sel (sel),
    .idx (idx)
  );
  always_comb begin
    sel_idx_d = idx;
    d_out_d = idx == IDX_D5 ? d5 :
              idx == IDX_D4 ? d4 :
              idx == IDX_D3 ? d3 :
              idx == IDX_D2 ? d2 :
              idx == IDX_D1 ? d1 : d0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_out_q <= '0;
      sel_idx_q <= IDX_D0;
    end else begin
      d_out_q <= d_out_d;
      sel_idx_q <= sel_idx_d;
    end
  assign d_out = d_out_q;
  assign sel_idx = sel_idx_q;
endmodule

// File: tb/tb_priority_mux_6_to_1.sv
// tb_priority_mux_6_to_1: table sweep, corner sequences and randomized model check
module tb_priority_mux_6_to_1;
  typedef struct {
    logic [4:0] sel;
    logic [7:0] exp_d;
    logic [2:0] exp_idx;
  } vec_t;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] d [6];
  logic [4:0] sel = 5'd5;
  logic [7:0] d_out;
  logic [2:0] sel_idx;
  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl [34];
  priority_mux_6_to_1 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d0      (d[0]),
    .d1      (d[1]),
    .d2      (d[2]),
    .d3      (d[3]),
    .d4      (d[4]),
    .d5      (d[5]),
    .sel     (sel),
    .d_out   (d_out),
    .sel_idx (sel_idx)
  );
  always #5 clk = ~clk;
  function automatic int model_idx(input logic [4:0] s);
    return $clog2(int'(s) + 1);
  endfunction
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_common;
    d[0] = 8'hB8; d[1] = 8'hF0; d[2] = 8'h55;
    d[3] = 8'h33; d[4] = 8'hE3; d[5] = 8'hAA;
  endtask
  initial begin
    set_common();
    for (int s = 0; s < 32; s++) begin
      tbl[s].sel = 5'(s);
      tbl[s].exp_idx = s == 0 ? 3'd0 : s == 1 ? 3'd1 : s < 4 ? 3'd2 :
                       s < 8 ? 3'd3 : s < 16 ? 3'd4 : 3'd5;
      tbl[s].exp_d = s == 0 ? 8'hB8 : s == 1 ? 8'hF0 : s < 4 ? 8'h55 :
                     s < 8 ? 8'h33 : s < 16 ? 8'hE3 : 8'hAA;
    end
    tbl[32] = '{5'b11111, 8'hAA, 3'd5};
    tbl[33] = '{5'b01111, 8'hE3, 3'd4};
    #1;
    chk("reset_imm_d", d_out, 8'h00);
    chk("reset_imm_idx", {5'd0, sel_idx}, 8'd0);
    tick(); tick();
    chk("reset_hold_d", d_out, 8'h00);
    chk("reset_hold_idx", {5'd0, sel_idx}, 8'd0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("reset_release_d", d_out, 8'h33);
    chk("reset_release_idx", {5'd0, sel_idx}, 8'd3);
    for (int i = 0; i < 34; i++) begin
      sel = tbl[i].sel;
      for (int k = 0; k < 2; k++) begin
        tick();
        chk($sformatf("tbl_d_sel%0d", tbl[i].sel), d_out, tbl[i].exp_d);
        chk($sformatf("tbl_idx_sel%0d", tbl[i].sel), {5'd0, sel_idx}, {5'd0, tbl[i].exp_idx});
      end
    end
    sel = 5'd0;
    tick();
    chk("lat_before", d_out, 8'hB8);
    sel = 5'd16;
    #3;
    chk("lat_hold", d_out, 8'hB8);
    tick();
    chk("lat_after", d_out, 8'hAA);
    sel = 5'd8;
    tick();
    chk("track_init", d_out, 8'hE3);
    d[4] = 8'h0F;
    tick();
    chk("track_d4", d_out, 8'h0F);
    d[5] = 8'h77;
    tick();
    chk("track_d5_ignored", d_out, 8'h0F);
    set_common();
    sel = 5'd31;
    tick();
    chk("async_pre", d_out, 8'hAA);
    #2;
    rst_n = 0;
    #1;
    chk("async_d", d_out, 8'h00);
    chk("async_idx", {5'd0, sel_idx}, 8'd0);
    tick();
    chk("async_hold", d_out, 8'h00);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 6; j++) d[j] = 8'($urandom);
      sel = 5'($urandom_range(0, 31));
      tick();
      chk($sformatf("rand_d_sel%0d", sel), d_out, d[model_idx(sel)]);
      chk($sformatf("rand_idx_sel%0d", sel), {5'd0, sel_idx}, 8'(model_idx(sel)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/priority_mux_6_to_1.md
Name: priority_mux_6_to_1

Overview:
Six-input, byte-wide priority multiplexer with a registered output. A 5-bit one-hot-or-more select chooses one data input. The highest set select bit wins, and an all-zero select falls back to d0. The block is used as a datapath source selector and is fully synchronous to a single clock, with an asynchronous active-low reset.

Parameters:
- WIDTH, 8, data width of d0..d5 and d_out.
- SEL_W, 5, select width. Fixed at 5 for six inputs; any other value is a compile-time error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- d0  input  WIDTH  data, selected when sel == 0
- d1  input  WIDTH  data, selected when the highest set bit is sel[0]
- d2  input  WIDTH  data, selected when the highest set bit is sel[1]
- d3  input  WIDTH  data, selected when the highest set bit is sel[2]
- d4  input  WIDTH  data, selected when the highest set bit is sel[3]
- d5  input  WIDTH  data, selected when the highest set bit is sel[4]
- sel  input  SEL_W  priority select
- d_out  output  WIDTH  registered selected data
- sel_idx  output  3  registered index (0..5) of the selected input

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Priority decode, combinational, from highest to lowest:
  - sel[4]=1 -> d5
  - else sel[3]=1 -> d4
  - else sel[2]=1 -> d3
  - else sel[1]=1 -> d2
  - else sel[0]=1 -> d1
  - else (sel == 5'b00000) -> d0
- Lower set bits are ignored whenever a higher bit is set.
- Equivalent ranges: sel 0 -> d0; 1 -> d1; 2..3 -> d2; 4..7 -> d3; 8..15 -> d4; 16..31 -> d5.
- sel_idx encodes the same decision: 0 for d0 through 5 for d5.
- Latency: exactly 1 clock. d_out and sel_idx are updated on each rising clk edge from the sel and d* values sampled at that edge.
- There is no enable; the registers load every cycle.
- Reset:
  - rst_n low immediately, without waiting for clk, forces d_out = 0 and sel_idx = 0.
  - The registers hold those values while rst_n is low.
  - The first load happens on the first rising clk edge after rst_n goes high.
- Reset mid-operation discards the in-flight value; there is no other state.
- X/Z on sel is not defined behaviour. The bench drives only known values.
- No wrap-around or handshake is involved; every one of the 32 sel codes is legal.

Decomposition:
- Shared package priority_mux_pkg holds:
  - DATA_W = 8
  - SEL_W = 5
  - NUM_IN = 6
  - index constants IDX_D0..IDX_D5 (3'd0..3'd5)
- Natural sub-module: pri_enc_5, a combinational 5-bit highest-set-bit encoder producing a 3-bit index (0 for all-zero).
- The top level instantiates pri_enc_5, muxes d0..d5 by the index, and registers d_out and sel_idx.

Test Plan:
Common setup: 10 ns clock; d0=8'hB8, d1=8'hF0, d2=8'h55, d3=8'h33, d4=8'hE3, d5=8'hAA; d_out checked one clock after each sel change.
1. Reset: hold rst_n=0 with sel=5 -> d_out=8'h00 and sel_idx=0 immediately and across clock edges. Release rst_n -> the next edge gives d_out=8'h33.
2. Sweep sel 0..31, each held 2 clocks, with the expected value:
   - sel 0 -> 8'hB8
   - sel 1 -> 8'hF0
   - sel 2..3 -> 8'h55
   - sel 4..7 -> 8'h33
   - sel 8..15 -> 8'hE3
   - sel 16..31 -> 8'hAA
   - Error count must be 0.
3. Priority override: sel=5'b11111 -> d_out=8'hAA, sel_idx=5; then sel=5'b01111 -> 8'hE3, sel_idx=4.
4. Latency: change sel 0 -> 16 just after an edge -> d_out stays 8'hB8 until the next rising edge, then becomes 8'hAA.
5. Data tracking: sel=8 fixed; change d4 from 8'hE3 to 8'h0F -> d_out=8'h0F one clock later. Changing d5 has no effect.
6. Async reset mid-run: sel=31 with d_out=8'hAA; drop rst_n between edges -> d_out=8'h00 and sel_idx=0 without a clock edge.
